// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master PicoRV32 memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_timeout.sv
// Saturating stall counter; expired is high during the cycle whose stall would reach the limit.
module mem_arb_timeout #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             count_en,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expired = ({1'b0, count} + {{WIDTH{1'b0}}, 1'b1}) >= {1'b0, limit};

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter for the PicoRV32 native memory bus.
// Define MEM_ARB_TIMEOUT_EN to add the hung-slave timeout, ABORT state and err pulse.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        err
);

  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  arb_state_e state, state_next;
  logic       last_grant;
  logic       expired;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic granted;
  assign granted = (state == GNT0) || (state == GNT1);

  mem_arb_timeout #(
    .WIDTH (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (!granted),
    .count_en (granted && !s_ready),
    .limit    (CNT_W'(TIMEOUT_CYCLES)),
    .expired  (expired)
  );

  assign err = (state == ABORT);
`else
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= MASTER1;
    end else begin
      state <= state_next;
      if (state_next == GNT0) begin
        last_grant <= MASTER0;
      end else if (state_next == GNT1) begin
        last_grant <= MASTER1;
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_next = state;
    grant      = 2'b00;
    s_valid    = 1'b0;
    s_instr    = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    m0_ready   = 1'b0;
    m0_rdata   = '0;
    m1_ready   = 1'b0;
    m1_rdata   = '0;

    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_next = (last_grant == MASTER0) ? GNT1 : GNT0;
        end else if (m0_valid) begin
          state_next = GNT0;
        end else if (m1_valid) begin
          state_next = GNT1;
        end
      end

      GNT0: begin
        grant    = 2'b01;
        s_valid  = m0_valid;
        s_instr  = m0_instr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready;
        m0_rdata = s_rdata;
        // A same-cycle s_ready beats the timeout: the transfer completes normally.
        if (s_ready || !m0_valid) begin
          state_next = IDLE;
        end else if (expired) begin
          state_next = ABORT;
        end
      end

      GNT1: begin
        grant    = 2'b10;
        s_valid  = m1_valid;
        s_instr  = m1_instr;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready;
        m1_rdata = s_rdata;
        if (s_ready || !m1_valid) begin
          state_next = IDLE;
        end else if (expired) begin
          state_next = ABORT;
        end
      end

      ABORT: begin
        // last_grant still names the master whose transfer is being aborted.
        state_next = IDLE;
        if (last_grant == MASTER0) begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end else begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned TO       = 4;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  mvalid, minstr;
  logic [31:0] maddr  [2];
  logic [31:0] mwdata [2];
  logic [3:0]  mwstrb [2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        err;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: who owns the bus, who is being aborted, and how long the owner has waited.
  int owner, abort_who, last, waited;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0_valid (mvalid[0]),
    .m0_instr (minstr[0]),
    .m0_addr  (maddr[0]),
    .m0_wdata (mwdata[0]),
    .m0_wstrb (mwstrb[0]),
    .m0_ready (m0_ready),
    .m0_rdata (m0_rdata),
    .m1_valid (mvalid[1]),
    .m1_instr (minstr[1]),
    .m1_addr  (maddr[1]),
    .m1_wdata (mwdata[1]),
    .m1_wstrb (mwstrb[1]),
    .m1_ready (m1_ready),
    .m1_rdata (m1_rdata),
    .s_valid  (s_valid),
    .s_instr  (s_instr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .grant    (grant),
    .err      (err)
  );

  task automatic idle_inputs();
    mvalid  = 2'b00;
    minstr  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      maddr[i]  = '0;
      mwdata[i] = '0;
      mwstrb[i] = '0;
    end
    s_ready = 1'b0;
    s_rdata = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn    = 1'b0;
    mvalid    = 2'b11;
    maddr[0]  = 32'h0000_0ABC;
    s_ready   = 1'b1;
    s_rdata   = 32'h1111_2222;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant got=%b exp=00", grant); end
    tests++; if ({s_valid, m0_ready, m1_ready, err} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=0000", {s_valid, m0_ready, m1_ready, err}); end
    tests++; if ({m0_rdata, m1_rdata, s_addr} !== 96'h0) begin
      fails++; $display("FAIL reset_data got=%h exp=0", {m0_rdata, m1_rdata, s_addr}); end
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    mvalid[0] = 1'b1; maddr[0] = 32'h0000_0010; mwstrb[0] = 4'b0000;
    #1;
    tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL rd_n_svalid got=%b exp=0", s_valid); end
    @(negedge clk); #1;
    tests++; if (s_valid !== 1'b1) begin fails++; $display("FAIL rd_n1_svalid got=%b exp=1", s_valid); end
    tests++; if (s_addr !== 32'h0000_0010) begin fails++; $display("FAIL rd_saddr got=%h exp=00000010", s_addr); end
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL rd_n1_grant got=%b exp=01", grant); end
    @(negedge clk); #1;
    tests++; if ({grant, m0_ready} !== 3'b010) begin fails++; $display("FAIL rd_n2 got=%b exp=010", {grant, m0_ready}); end
    @(negedge clk);
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    tests++; if ({grant, m0_ready, m1_ready} !== 4'b0110) begin
      fails++; $display("FAIL rd_n3_ready got=%b exp=0110", {grant, m0_ready, m1_ready}); end
    tests++; if (m0_rdata !== 32'h1234_5678) begin fails++; $display("FAIL rd_rdata got=%h exp=12345678", m0_rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL rd_after_grant got=%b exp=00", grant); end
  endtask

  task automatic test_round_robin();
    logic [1:0] pat [8];
    pat = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    pulse_reset();
    mvalid = 2'b11; maddr[0] = 32'h100; maddr[1] = 32'h200;
    s_ready = 1'b1; s_rdata = 32'hCAFE_0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++; if ({grant, m1_ready, m0_ready} !== {pat[i], pat[i]}) begin
        fails++; $display("FAIL rr_cycle%0d got=%b exp=%b", i, {grant, m1_ready, m0_ready}, {pat[i], pat[i]}); end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_contention();
    mvalid[0] = 1'b1; maddr[0] = 32'h20;
    #1;
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL ct_n_grant got=%b exp=00", grant); end
    @(negedge clk);
    mvalid[1] = 1'b1; maddr[1] = 32'h40;
    for (int k = 1; k <= 3; k++) begin
      #1;
      tests++; if ({grant, m1_ready, m0_ready} !== 4'b0100) begin
        fails++; $display("FAIL ct_stall%0d got=%b exp=0100", k, {grant, m1_ready, m0_ready}); end
      @(negedge clk);
    end
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    #1;
    tests++; if ({m1_ready, m0_ready} !== 2'b01) begin fails++; $display("FAIL ct_done got=%b exp=01", {m1_ready, m0_ready}); end
    @(negedge clk);
    mvalid[0] = 1'b0; s_ready = 1'b0;
    #1;
    tests++; if ({grant, m1_ready} !== 3'b000) begin fails++; $display("FAIL ct_bubble got=%b exp=000", {grant, m1_ready}); end
    @(negedge clk);
    s_ready = 1'b1;
    #1;
    tests++; if ({grant, m1_ready, m0_ready} !== 4'b1010) begin
      fails++; $display("FAIL ct_m1_next got=%b exp=1010", {grant, m1_ready, m0_ready}); end
    tests++; if (s_addr !== 32'h40) begin fails++; $display("FAIL ct_m1_addr got=%h exp=00000040", s_addr); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_write_m1();
    mvalid[1] = 1'b1; maddr[1] = 32'h0200_0000; mwdata[1] = 32'h0000_00A5; mwstrb[1] = 4'b0001;
    maddr[0] = 32'hFFFF_FFFF; mwdata[0] = 32'hFFFF_FFFF; mwstrb[0] = 4'b1111;
    @(negedge clk);
    s_ready = 1'b1; s_rdata = 32'h5A5A_0001;
    #1;
    tests++; if ({grant, s_valid} !== 3'b101) begin fails++; $display("FAIL wr_grant got=%b exp=101", {grant, s_valid}); end
    tests++; if ({s_addr, s_wdata, s_wstrb} !== {32'h0200_0000, 32'h0000_00A5, 4'b0001}) begin
      fails++; $display("FAIL wr_fields got=%h exp=%h", {s_addr, s_wdata, s_wstrb}, {32'h0200_0000, 32'h0000_00A5, 4'b0001}); end
    tests++; if ({m0_ready, m0_rdata} !== 33'h0) begin fails++; $display("FAIL wr_m0_quiet got=%h exp=0", {m0_ready, m0_rdata}); end
    tests++; if ({m1_ready, m1_rdata} !== {1'b1, 32'h5A5A_0001}) begin
      fails++; $display("FAIL wr_m1_ready got=%h exp=15a5a0001", {m1_ready, m1_rdata}); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    mvalid[0] = 1'b1; maddr[0] = 32'h30; s_rdata = 32'h7777_0000;
    #1;
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL to_n_grant got=%b exp=00", grant); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      tests++; if ({grant, m0_ready, err} !== 4'b0100) begin
        fails++; $display("FAIL to_wait%0d got=%b exp=0100", k, {grant, m0_ready, err}); end
    end
    @(negedge clk); #1;
`ifdef MEM_ARB_TIMEOUT_EN
    tests++; if ({grant, s_valid, m0_ready, m1_ready, err} !== 6'b000101) begin
      fails++; $display("FAIL to_abort got=%b exp=000101", {grant, s_valid, m0_ready, m1_ready, err}); end
    tests++; if (m0_rdata !== ERR_WORD) begin fails++; $display("FAIL to_err_rdata got=%h exp=%h", m0_rdata, ERR_WORD); end
    @(negedge clk);
    mvalid[0] = 1'b0;
    #1;
    tests++; if ({grant, m0_ready, err} !== 4'b0000) begin
      fails++; $display("FAIL to_after got=%b exp=0000", {grant, m0_ready, err}); end
`else
    for (int k = 5; k <= 8; k++) begin
      tests++; if ({grant, m0_ready, err} !== 4'b0100) begin
        fails++; $display("FAIL to_noabort%0d got=%b exp=0100", k, {grant, m0_ready, err}); end
      @(negedge clk); #1;
    end
    s_ready = 1'b1;
    #1;
    tests++; if ({m0_ready, m0_rdata} !== {1'b1, 32'h7777_0000}) begin
      fails++; $display("FAIL to_late_done got=%h exp=177770000", {m0_ready, m0_rdata}); end
`endif
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    mvalid[1] = 1'b1; maddr[1] = 32'h0000_0F00;
    @(negedge clk); #1;
    tests++; if (grant !== 2'b10) begin fails++; $display("FAIL ar_gnt1 got=%b exp=10", grant); end
    #1;
    resetn  = 1'b0;
    s_ready = 1'b1;
    s_rdata = 32'h3333_4444;
    #1;
    tests++; if ({grant, s_valid, m1_ready, m0_ready, err} !== 6'b0) begin
      fails++; $display("FAIL ar_async got=%b exp=000000", {grant, s_valid, m1_ready, m0_ready, err}); end
    tests++; if ({s_addr, m1_rdata} !== 64'h0) begin fails++; $display("FAIL ar_async_data got=%h exp=0", {s_addr, m1_rdata}); end
    @(negedge clk);
    resetn = 1'b1; s_ready = 1'b0; mvalid = 2'b11; maddr[0] = 32'h0000_0A00;
    #1;
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL ar_idle got=%b exp=00", grant); end
    @(negedge clk); #1;
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL ar_first_m0 got=%b exp=01", grant); end
    s_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          pend [2];
    int          pick;
    logic [1:0]  e_grant, e_rdy;
    logic        e_sv, e_si, e_err;
    logic [31:0] e_sa, e_sw, e_rd [2];
    logic [3:0]  e_ss;
    logic [138:0] act, exp;
    pulse_reset();
    owner = -1; abort_who = -1; last = 1; waited = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && $urandom_range(31) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i]   = 1'b1;
          minstr[i] = 1'($urandom_range(1));
          maddr[i]  = $urandom;
          mwdata[i] = $urandom;
          mwstrb[i] = 4'($urandom_range(15));
        end
      end
      mvalid  = {pend[1], pend[0]};
      s_ready = ($urandom_range(2) == 0);
      s_rdata = $urandom;
      #1;
      e_grant = '0; e_rdy = '0; e_sv = 1'b0; e_si = 1'b0; e_err = 1'b0;
      e_sa = '0; e_sw = '0; e_ss = '0; e_rd[0] = '0; e_rd[1] = '0;
      if (abort_who >= 0) begin
        e_rdy[abort_who] = 1'b1; e_rd[abort_who] = ERR_WORD; e_err = 1'b1;
      end else if (owner >= 0) begin
        e_grant[owner] = 1'b1;
        e_sv = mvalid[owner]; e_si = minstr[owner];
        e_sa = maddr[owner]; e_sw = mwdata[owner]; e_ss = mwstrb[owner];
        e_rdy[owner] = s_ready; e_rd[owner] = s_rdata;
      end
      act = {grant, s_valid, s_instr, s_addr, s_wdata, s_wstrb, m1_ready, m0_ready, m0_rdata, m1_rdata, err};
      exp = {e_grant, e_sv, e_si, e_sa, e_sw, e_ss, e_rdy, e_rd[0], e_rd[1], e_err};
      tests++; if (act !== exp) begin fails++; $display("FAIL rand_cycle%0d got=%h exp=%h", cyc, act, exp); end
      for (int i = 0; i < 2; i++) if (pend[i] && e_rdy[i]) pend[i] = 1'b0;
      if (abort_who >= 0) begin
        abort_who = -1;
      end else if (owner < 0) begin
        if (mvalid == 2'b11) pick = (last == 1) ? 0 : 1;
        else if (mvalid[0]) pick = 0;
        else if (mvalid[1]) pick = 1;
        else pick = -1;
        if (pick >= 0) begin owner = pick; last = pick; waited = 0; end
      end else if (s_ready || !mvalid[owner]) begin
        owner = -1;
      end else begin
        waited++;
        if (TO_EN && waited == int'(TO)) begin abort_who = owner; owner = -1; end
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_contention();
    test_write_m1();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
